// File: rtl/sync_down_counter.sv
// Synchronous modulo-MODULUS down counter built from per-bit toggle stages.
// It supports parallel load with clamping, borrow-out for cascading, and a one-shot stop mode.
module sync_down_counter_stage #(
  parameter logic RST = 1'b0
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q
);
  always_ff @(negedge Clock) begin
    if (!Resetn)  q <= RST;
    else if (ld)  q <= d;
    else if (t)   q <= ~q;
  end
endmodule

module sync_down_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             OneShot,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Done
);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
  localparam logic             RUN  = 1'b0;
  localparam logic             HOLD = 1'b1;

  logic             state;
  logic             zero, dec, wrap, stop, ld_any;
  logic [WIDTH-1:0] ld_val, tgl;

  assign zero   = (Q == '0);
  assign dec    = En & (state == RUN) & ~Load;
  assign wrap   = dec & zero & ~OneShot;
  assign stop   = dec & zero & OneShot;
  // A wrap is a synchronous load of TOP, so Q never reaches an out-of-range code.
  assign ld_any = Load | wrap;
  assign ld_val = Load ? ((D > TOP) ? TOP : D) : TOP;
  assign Tc     = En & zero & (state == RUN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign tgl[i] = dec & ~zero;
    end else begin : g_upper
      assign tgl[i] = dec & ~zero & ~|Q[i-1:0];
    end
    sync_down_counter_stage #(.RST(TOP[i])) u_stage (
      .Clock  (Clock),
      .Resetn (Resetn),
      .ld     (ld_any),
      .d      (ld_val[i]),
      .t      (tgl[i]),
      .q      (Q[i])
    );
  end

  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      state <= RUN;
      Done  <= 1'b0;
    end else if (Load) begin
      state <= RUN;
      Done  <= 1'b0;
    end else if (stop) begin
      state <= HOLD;
      Done  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_down_counter.sv
// Directed-vector bench for sync_down_counter: modulus-16 reset/count, modulus-10 table,
// wrap run and a two-stage cascade.
module tb_sync_down_counter;
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int ncmp = 0;
  int nerr = 0;

  // modulus-16 instance
  logic       a_rstn, a_en, a_ld, a_os;
  logic [3:0] a_d, a_q;
  logic       a_tc, a_done;
  // modulus-10 instance
  logic       b_rstn, b_en, b_ld, b_os;
  logic [3:0] b_d, b_q;
  logic       b_tc, b_done;
  // cascade: hi counts on lo borrow
  logic       c_rstn, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_done, hi_done;

  sync_down_counter #(.WIDTH(4), .MODULUS(16)) u_a (
    .Clock(Clock), .Resetn(a_rstn), .En(a_en), .Load(a_ld), .D(a_d),
    .OneShot(a_os), .Q(a_q), .Tc(a_tc), .Done(a_done));
  sync_down_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .Clock(Clock), .Resetn(b_rstn), .En(b_en), .Load(b_ld), .D(b_d),
    .OneShot(b_os), .Q(b_q), .Tc(b_tc), .Done(b_done));
  sync_down_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .Clock(Clock), .Resetn(c_rstn), .En(c_en), .Load(1'b0), .D(4'd0),
    .OneShot(1'b0), .Q(lo_q), .Tc(lo_tc), .Done(lo_done));
  sync_down_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .Clock(Clock), .Resetn(c_rstn), .En(lo_tc), .Load(1'b0), .D(4'd0),
    .OneShot(1'b0), .Q(hi_q), .Tc(hi_tc), .Done(hi_done));

  typedef struct {
    logic       rstn, en, ld, os;
    logic [3:0] d;
    logic       tc;    // Tc with these inputs, before the edge
    logic [3:0] q;     // after the edge
    logic       done;  // after the edge
  } vec_t;

  vec_t tv[28];

  function automatic vec_t mk(logic rstn, logic en, logic ld, logic [3:0] d, logic os,
                              logic tc, logic [3:0] q, logic done);
    vec_t v;
    v.rstn = rstn; v.en = en; v.ld = ld; v.d = d; v.os = os;
    v.tc = tc; v.q = q; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    //            rstn en ld d  os  tc  q  done
    tv[0]  = mk(1, 1, 1, 13, 0, 0, 9, 0);  // clamp, load beats En
    tv[1]  = mk(1, 0, 1, 4,  0, 0, 4, 0);
    tv[2]  = mk(1, 0, 1, 3,  0, 0, 3, 0);
    tv[3]  = mk(1, 1, 0, 0,  1, 0, 2, 0);
    tv[4]  = mk(1, 1, 0, 0,  1, 0, 1, 0);
    tv[5]  = mk(1, 1, 0, 0,  1, 0, 0, 0);
    tv[6]  = mk(1, 1, 0, 0,  1, 1, 0, 1);  // one-shot expires
    tv[7]  = mk(1, 1, 0, 0,  1, 0, 0, 1);
    tv[8]  = mk(1, 1, 0, 0,  0, 0, 0, 1);  // HOLD ignores En/OneShot
    tv[9]  = mk(1, 0, 0, 0,  0, 0, 0, 1);
    tv[10] = mk(1, 1, 1, 5,  1, 0, 5, 0);  // reload leaves HOLD
    tv[11] = mk(1, 1, 0, 0,  1, 0, 4, 0);
    tv[12] = mk(1, 1, 0, 0,  1, 0, 3, 0);
    tv[13] = mk(1, 0, 0, 0,  1, 0, 3, 0);
    tv[14] = mk(1, 0, 1, 7,  0, 0, 7, 0);
    tv[15] = mk(1, 0, 0, 0,  0, 0, 7, 0);
    tv[16] = mk(1, 0, 0, 0,  0, 0, 7, 0);
    tv[17] = mk(1, 1, 0, 0,  0, 0, 6, 0);
    tv[18] = mk(0, 1, 1, 2,  0, 0, 9, 0);  // reset beats Load mid-count
    tv[19] = mk(1, 0, 1, 0,  0, 0, 0, 0);
    tv[20] = mk(1, 1, 0, 0,  1, 1, 0, 1);
    tv[21] = mk(0, 1, 1, 2,  1, 0, 9, 0);  // reset out of HOLD
    tv[22] = mk(1, 1, 0, 0,  1, 0, 8, 0);  // counting again proves RUN
    tv[23] = mk(1, 0, 1, 0,  0, 0, 0, 0);
    tv[24] = mk(1, 1, 0, 0,  0, 1, 9, 0);  // wrap to MODULUS-1
    tv[25] = mk(1, 0, 1, 9,  0, 0, 9, 0);
    tv[26] = mk(1, 0, 1, 10, 0, 0, 9, 0);
    tv[27] = mk(1, 0, 1, 15, 0, 0, 9, 0);

    a_rstn = 0; a_en = 0; a_ld = 0; a_d = 0; a_os = 0;
    b_rstn = 0; b_en = 0; b_ld = 0; b_d = 0; b_os = 0;
    c_rstn = 0; c_en = 0;

    // modulus-16 reset held for two edges, then count down
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock); #1;
      chk("a_reset_q", a_q, 15);
      chk("a_reset_done", a_done, 0);
      chk("a_reset_tc", a_tc, 0);
    end
    @(posedge Clock); a_rstn = 1; a_en = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock); #1;
      chk("a_count_q", a_q, 15 - k);
    end

    // modulus-10 vector table
    for (int i = 0; i < 28; i++) begin
      @(posedge Clock);
      b_rstn = tv[i].rstn; b_en = tv[i].en; b_ld = tv[i].ld;
      b_d = tv[i].d; b_os = tv[i].os;
      #1 chk($sformatf("b_tc[%0d]", i), b_tc, tv[i].tc);
      @(negedge Clock); #1;
      chk($sformatf("b_q[%0d]", i), b_q, tv[i].q);
      chk($sformatf("b_done[%0d]", i), b_done, tv[i].done);
    end

    // wrap run: 25 edges from reset
    @(posedge Clock); b_rstn = 0; b_ld = 0; b_en = 0; b_os = 0;
    @(negedge Clock); #1 chk("wrap_reset_q", b_q, 9);
    @(posedge Clock); b_rstn = 1; b_en = 1;
    for (int k = 1; k <= 25; k++) begin
      int prev, nxt;
      prev = (((9 - (k - 1)) % 10) + 10) % 10;
      nxt  = (((9 - k) % 10) + 10) % 10;
      if (k > 1) @(posedge Clock);
      #1 chk($sformatf("wrap_tc[%0d]", k), b_tc, (prev == 0) ? 1 : 0);
      @(negedge Clock); #1;
      chk($sformatf("wrap_q[%0d]", k), b_q, nxt);
      chk($sformatf("wrap_range[%0d]", k), (b_q <= 4'd9) ? 1 : 0, 1);
    end

    // cascade: hi decrements only at edges where lo wraps (k = 10, 20)
    @(posedge Clock); c_rstn = 1; c_en = 1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge Clock); #1;
      chk($sformatf("casc_lo[%0d]", k), lo_q, (((9 - k) % 10) + 10) % 10);
      chk($sformatf("casc_hi[%0d]", k), hi_q, 9 - k / 10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
